// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg
// Shared definitions for the multicycle RISC-V controller:
//   - FSM state encodings (state_t, 4-bit, values 0..10; 11..15 unused)
//   - opcode constants for the supported instruction classes
//   - ALUControl codes and ImmSrc codes
//   - imm_src_of(): immediate-format decode from the opcode
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every
    // state; unknown opcodes fall back to the I format.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src_of = IMM_S;
            OP_BEQ:  imm_src_of = IMM_B;
            OP_JAL:  imm_src_of = IMM_J;
            default: imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// ALU function decode for the execute states.
// Ports:
//   op          in  7  opcode (only the R-type check matters here)
//   funct3      in  3  Instr[14:12]
//   funct7b5    in  1  Instr[30]
//   alu_control out 2  00 add, 01 sub, 10 and, 11 or
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            // Only R-type uses funct7b5 to select subtract; addi has no subi.
            3'b000:  alu_control = ((op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control = ALU_AND;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle RISC-V control unit (lw, sw, R-type, I-ALU, beq, jal).
// Ports:
//   clk, reset (sync, active-low)
//   op, funct3, funct7b5     instruction fields
//   Zero                     ALU zero flag (gates PCWrite in BEQ)
//   MemReady                 memory handshake (ignored when MEMREADY_EN = 0)
//   PCWrite, IRWrite, MemWrite, RegWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl   datapath selects
//   Illegal                  high in DECODE when the opcode is unsupported
//   State                    current FSM state (debug)
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int MEMREADY_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state_reg;
    state_t     state_next;
    logic       mem_ready;
    logic [1:0] alu_dec_ctrl;

    // Raw enables before the reset override.
    logic pcwrite_c, irwrite_c, memwrite_c, regwrite_c;

    assign mem_ready = (MEMREADY_EN != 0) ? MemReady : 1'b1;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // PC+4 computed and written back in the same cycle the
                // instruction is latched; both wait for memory.
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                irwrite_c  = mem_ready;
                pcwrite_c  = mem_ready;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch/jump target OldPC + imm is precomputed here.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_IALU:      state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        Illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // Write strobe stays up for the whole wait so slow memory
                // sees a stable request.
                AdrSrc     = 1'b1;
                memwrite_c = 1'b1;
                state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec_ctrl;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec_ctrl;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut still holds the target from DECODE; the ALU compares.
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pcwrite_c  = Zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC <- target (ALUOut) while ALU forms OldPC+4 for rd.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcwrite_c  = 1'b1;
                state_next = S_ALUWB;
            end
            default: begin
                // Unused encodings: all outputs at defaults, recover to FETCH.
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset gates the enables combinationally so an aborted instruction can
    // never complete a write, even in the cycle reset is first asserted.
    assign PCWrite  = reset & pcwrite_c;
    assign IRWrite  = reset & irwrite_c;
    assign MemWrite = reset & memwrite_c;
    assign RegWrite = reset & regwrite_c;

    assign ImmSrc = imm_src_of(op);
    assign State  = state_reg;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Directed bench for mc_controller. Inputs change just after a falling edge;
// outputs are checked 1 ns later, well away from the rising edge.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0] State;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEMREADY_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .Illegal    (Illegal),
        .State      (State)
    );

    task automatic test_reset();
        reset = 1'b0; MemReady = 1'b1; op = 7'b0000011;
        funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (State !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", State); end
        n_cmp++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_enables: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (IRWrite !== 1'b1 || State !== 4'd0) begin
            n_bad++; $display("FAIL reset_release_irwrite: got IRWrite=%b State=%0d want 1/0", IRWrite, State);
        end
        $display("txn reset: done");
    endtask

    task automatic test_lw();
        logic [3:0] seq [6];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        op = 7'b0000011; MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (State !== seq[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, seq[i]); end
            n_cmp++;
            if (RegWrite !== (seq[i] == 4'd4)) begin
                n_bad++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, RegWrite, seq[i] == 4'd4);
            end
            if (seq[i] == 4'd4) begin
                n_cmp++;
                if (ResultSrc !== 2'b01) begin n_bad++; $display("FAIL lw_resultsrc: got %b want 01", ResultSrc); end
            end
            if (i < 5) @(negedge clk);
        end
        $display("txn lw: done");
    endtask

    task automatic test_sw_wait();
        op = 7'b0100011; MemReady = 1'b1;
        #1;
        n_cmp++;
        if (ImmSrc !== 2'b01) begin n_bad++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc); end
        @(negedge clk);   // DECODE
        @(negedge clk);   // MEMADR
        #1;
        n_cmp++;
        if (State !== 4'd2 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01) begin
            n_bad++; $display("FAIL sw_memadr: got State=%0d A=%b B=%b want 2/10/01", State, ALUSrcA, ALUSrcB);
        end
        MemReady = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            MemReady = (k == 3);
            #1;
            n_cmp++;
            if (State !== 4'd5 || MemWrite !== 1'b1 || AdrSrc !== 1'b1) begin
                n_bad++; $display("FAIL sw_wait[%0d]: got State=%0d MemWrite=%b AdrSrc=%b want 5/1/1", k, State, MemWrite, AdrSrc);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (State !== 4'd0 || MemWrite !== 1'b0) begin
            n_bad++; $display("FAIL sw_done: got State=%0d MemWrite=%b want 0/0", State, MemWrite);
        end
        $display("txn sw with 3 wait cycles: done");
    endtask

    task automatic test_alu_ops();
        logic [6:0] t_op  [6];
        logic [2:0] t_f3  [6];
        logic       t_f7  [6];
        logic [3:0] t_st  [6];
        logic [1:0] t_ctl [6];
        t_op  = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011};
        t_f3  = '{3'b000,     3'b000,     3'b000,     3'b111,     3'b110,     3'b010};
        t_f7  = '{1'b1,       1'b1,       1'b0,       1'b0,       1'b1,       1'b1};
        t_st  = '{4'd6,       4'd7,       4'd6,       4'd6,       4'd7,       4'd6};
        t_ctl = '{2'b01,      2'b00,      2'b00,      2'b10,      2'b11,      2'b00};
        MemReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
            @(negedge clk);   // DECODE
            @(negedge clk);   // EXECUTE
            #1;
            n_cmp++;
            if (State !== t_st[i] || ALUControl !== t_ctl[i]) begin
                n_bad++; $display("FAIL alu[%0d]: got State=%0d ALUControl=%b want %0d/%b", i, State, ALUControl, t_st[i], t_ctl[i]);
            end
            n_cmp++;
            if (ALUSrcB !== ((t_st[i] == 4'd7) ? 2'b01 : 2'b00)) begin
                n_bad++; $display("FAIL alu_srcb[%0d]: got %b", i, ALUSrcB);
            end
            @(negedge clk);   // ALUWB
            #1;
            n_cmp++;
            if (State !== 4'd8 || RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin
                n_bad++; $display("FAIL aluwb[%0d]: got State=%0d RegWrite=%b ResultSrc=%b want 8/1/00", i, State, RegWrite, ResultSrc);
            end
            @(negedge clk);   // FETCH
            #1;
            n_cmp++;
            if (State !== 4'd0) begin n_bad++; $display("FAIL alu_ret[%0d]: got %0d want 0", i, State); end
            $display("txn alu op=%b f3=%b f7b5=%b: ALUControl=%b", t_op[i], t_f3[i], t_f7[i], t_ctl[i]);
        end
    endtask

    task automatic test_beq();
        logic zv;
        op = 7'b1100011; MemReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            zv = (i == 0);
            Zero = zv;
            @(negedge clk);   // DECODE
            #1;
            n_cmp++;
            if (ImmSrc !== 2'b10) begin n_bad++; $display("FAIL beq_immsrc: got %b want 10", ImmSrc); end
            @(negedge clk);   // BEQ
            #1;
            n_cmp++;
            if (State !== 4'd9 || PCWrite !== zv || ALUControl !== 2'b01) begin
                n_bad++; $display("FAIL beq[%0d]: got State=%0d PCWrite=%b ALUControl=%b want 9/%b/01", i, State, PCWrite, ALUControl, zv);
            end
            @(negedge clk);
            #1;
            n_cmp++;
            if (State !== 4'd0) begin n_bad++; $display("FAIL beq_ret[%0d]: got %0d want 0", i, State); end
            $display("txn beq Zero=%b: PCWrite=%b", zv, zv);
        end
        Zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111; MemReady = 1'b1;
        @(negedge clk);   // DECODE
        @(negedge clk);   // JAL
        #1;
        n_cmp++;
        if (State !== 4'd10 || PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10 || ImmSrc !== 2'b11) begin
            n_bad++; $display("FAIL jal: got State=%0d PCWrite=%b A=%b B=%b Imm=%b want 10/1/01/10/11", State, PCWrite, ALUSrcA, ALUSrcB, ImmSrc);
        end
        @(negedge clk);   // ALUWB
        #1;
        n_cmp++;
        if (State !== 4'd8 || RegWrite !== 1'b1) begin
            n_bad++; $display("FAIL jal_wb: got State=%0d RegWrite=%b want 8/1", State, RegWrite);
        end
        @(negedge clk);
        $display("txn jal: done");
    endtask

    task automatic test_illegal();
        op = 7'b1111111; MemReady = 1'b1;
        #1;
        n_cmp++;
        if (Illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_fetch: got %b want 0", Illegal); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (State !== 4'd1 || Illegal !== 1'b1) begin
            n_bad++; $display("FAIL illegal_decode: got State=%0d Illegal=%b want 1/1", State, Illegal);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (State !== 4'd0 || Illegal !== 1'b0) begin
            n_bad++; $display("FAIL illegal_ret: got State=%0d Illegal=%b want 0/0", State, Illegal);
        end
        $display("txn illegal op: done");
    endtask

    task automatic test_reset_abort();
        op = 7'b0100011; MemReady = 1'b1;
        @(negedge clk);   // DECODE
        MemReady = 1'b0;
        @(negedge clk);   // MEMADR
        @(negedge clk);   // MEMWRITE
        #1;
        n_cmp++;
        if (State !== 4'd5 || MemWrite !== 1'b1) begin
            n_bad++; $display("FAIL abort_pre: got State=%0d MemWrite=%b want 5/1", State, MemWrite);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (MemWrite !== 1'b0) begin n_bad++; $display("FAIL abort_memwrite: got %b want 0", MemWrite); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (State !== 4'd0 || {PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            n_bad++; $display("FAIL abort_state: got State=%0d en=%b want 0/0000", State, {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (State !== 4'd0 || MemWrite !== 1'b0 || Illegal !== 1'b0) begin
            n_bad++; $display("FAIL abort_after: got State=%0d MemWrite=%b Illegal=%b want 0/0/0", State, MemWrite, Illegal);
        end
        $display("txn reset during sw wait: done");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_alu_ops();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
